// File: rtl/tone_sequencer_pkg.sv
// Shared types and default widths for the tone sequencer and its table.
package tone_sequencer_pkg;

  localparam int DW_DEF = 12;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // One programmed tone: two phase increments and a dwell length in cycles.
  typedef struct packed {
    logic [DW_DEF-1:0] delta_a;
    logic [DW_DEF-1:0] delta_b;
    logic [CW_DEF-1:0] dur;
  } tone_entry_t;

endpackage

// File: rtl/tone_sequencer_table.sv
// Tone table: register file with a synchronous write port and a combinational
// read port. A same-cycle write and read of one address returns the old entry.
module tone_table
  import tone_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  tone_entry_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output tone_entry_t   rd_data
);

  tone_entry_t mem [DEPTH];

  // Table storage is deliberately not reset; software programs it before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays table entries in order onto the sine-sum generator
// phase increments, with optional silent gaps, one-shot or looping playback.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_delta_a,
  input  logic [DW-1:0] wr_delta_b,
  input  logic [CW-1:0] wr_dur,
  input  logic [AW:0]   num_entries,
  input  logic [CW-1:0] gap_len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [DW-1:0] delta_a,
  output logic [DW-1:0] delta_b,
  output logic          tone_on,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] idx_d;
  logic [DW-1:0] delta_a_d, delta_b_d;
  logic          tone_on_d, busy_d, done_d;

  logic [AW-1:0] rd_addr;
  tone_entry_t   rd_entry;
  tone_entry_t   wr_entry;
  logic [AW:0]   n_clamp;
  logic          advance;
  logic          load;

  assign wr_entry = '{delta_a: wr_delta_a, delta_b: wr_delta_b, dur: wr_dur};

  tone_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // Requests above the table size play the whole table.
  always_comb begin
    n_clamp = num_entries;
    if (num_entries > (AW+1)'(DEPTH)) begin
      n_clamp = (AW+1)'(DEPTH);
    end
  end

  // Next-state, next-output and table read address for the playback FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = cur_idx;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    last_d    = last_q;
    delta_a_d = delta_a;
    delta_b_d = delta_b;
    tone_on_d = tone_on;
    done_d    = 1'b0;
    advance   = 1'b0;
    load      = 1'b0;
    rd_addr   = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (num_entries != '0)) begin
          // Run configuration is frozen here; loop stays live.
          last_d = AW'(n_clamp - (AW+1)'(1));
          gap_d  = gap_len;
          idx_d  = '0;
          load   = 1'b1;
        end
      end
      TONE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (gap_q != '0) begin
          state_d   = GAP;
          cnt_d     = gap_q - CW'(1);
          delta_a_d = '0;
          delta_b_d = '0;
          tone_on_d = 1'b0;
        end else begin
          advance = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (cur_idx != last_q) begin
        rd_addr = cur_idx + AW'(1);
        idx_d   = cur_idx + AW'(1);
        load    = 1'b1;
      end else if (loop) begin
        rd_addr = '0;
        idx_d   = '0;
        load    = 1'b1;
      end else begin
        state_d   = DONE;
        done_d    = 1'b1;
        delta_a_d = '0;
        delta_b_d = '0;
        tone_on_d = 1'b0;
      end
    end

    // Entry is captured into the output and dwell registers on entry to TONE,
    // so later table writes only show up at the next load of that entry.
    if (load) begin
      state_d   = TONE;
      delta_a_d = rd_entry.delta_a;
      delta_b_d = rd_entry.delta_b;
      tone_on_d = 1'b1;
      cnt_d     = (rd_entry.dur == '0) ? '0 : rd_entry.dur - CW'(1);
    end

    // Abort overrides everything else; cur_idx keeps the last played entry.
    if (stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      idx_d     = cur_idx;
      delta_a_d = '0;
      delta_b_d = '0;
      tone_on_d = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      cur_idx <= '0;
      delta_a <= '0;
      delta_b <= '0;
      tone_on <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      cur_idx <= idx_d;
      delta_a <= delta_a_d;
      delta_b <= delta_b_d;
      tone_on <= tone_on_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a cycle-level playback model.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_delta_a, wr_delta_b;
  logic [15:0] wr_dur;
  logic [4:0]  num_entries;
  logic [15:0] gap_len;
  logic        loop, start, stop;
  logic [11:0] delta_a, delta_b;
  logic        tone_on, busy, done;
  logic [3:0]  cur_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  tone_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_delta_a(wr_delta_a), .wr_delta_b(wr_delta_b), .wr_dur(wr_dur),
    .num_entries(num_entries), .gap_len(gap_len), .loop(loop),
    .start(start), .stop(stop), .delta_a(delta_a), .delta_b(delta_b),
    .tone_on(tone_on), .busy(busy), .cur_idx(cur_idx), .done(done)
  );

  // Playback model: segments of known length, table mirrored as int arrays.
  int          m_mode;  // 0 none, 1 playing a tone, 2 silent gap, 3 end pulse
  int          m_left, m_n, m_gap, m_idx;
  int          mt_a[16], mt_b[16], mt_d[16];
  logic [11:0] e_da, e_db;
  logic        e_ton, e_busy, e_done;
  logic [3:0]  e_idx;
  bit          m_valid = 0;

  function automatic void m_play(int i);
    m_idx  = i;
    m_mode = 1;
    e_idx  = 4'(i);
    e_da   = 12'(mt_a[i]);
    e_db   = 12'(mt_b[i]);
    e_ton  = 1'b1;
    m_left = (mt_d[i] == 0) ? 1 : mt_d[i];
  endfunction

  function automatic void m_silence();
    e_da  = '0;
    e_db  = '0;
    e_ton = 1'b0;
  endfunction

  function automatic void m_next();
    if (m_idx + 1 < m_n) m_play(m_idx + 1);
    else if (loop) m_play(0);
    else begin
      m_mode = 3;
      e_done = 1'b1;
      m_silence();
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_idx = 0; e_idx = '0; e_done = 1'b0; e_busy = 1'b0;
      m_silence();
      m_valid = 1;
    end else begin
      e_done = 1'b0;
      if (stop && m_mode != 0) begin
        m_mode = 0;
        m_silence();
      end else begin
        case (m_mode)
          0: if (start && !stop && num_entries != 0) begin
               m_n   = (num_entries > 16) ? 16 : int'(num_entries);
               m_gap = int'(gap_len);
               m_play(0);
             end
          1: begin
               m_left--;
               if (m_left == 0) begin
                 if (m_gap > 0) begin
                   m_mode = 2; m_left = m_gap; m_silence();
                 end else m_next();
               end
             end
          2: begin
               m_left--;
               if (m_left == 0) m_next();
             end
          default: m_mode = 0;
        endcase
      end
      e_busy = (m_mode != 0);
      if (wr_en) begin
        mt_a[wr_addr] = int'(wr_delta_a);
        mt_b[wr_addr] = int'(wr_delta_b);
        mt_d[wr_addr] = int'(wr_dur);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({delta_a, delta_b, tone_on, busy, cur_idx, done} !==
          {e_da, e_db, e_ton, e_busy, e_idx, e_done}) begin
        errors++;
        $display("FAIL model t=%0t: got da=%0d db=%0d on=%b busy=%b idx=%0d done=%b, expected da=%0d db=%0d on=%b busy=%b idx=%0d done=%b",
                 $time, delta_a, delta_b, tone_on, busy, cur_idx, done,
                 e_da, e_db, e_ton, e_busy, e_idx, e_done);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int da, input int db, input int d);
    wr_addr = 4'(a); wr_delta_a = 12'(da); wr_delta_b = 12'(db); wr_dur = 16'(d);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_count(input string nm, output int n);
    n = 0;
    for (int k = 0; k < 2000 && busy === 1'b1; k++) begin
      n++;
      @(negedge clk);
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    for (int i = 0; i < 16; i++) begin mt_a[i] = 0; mt_b[i] = 0; mt_d[i] = 0; end
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_delta_a = '0; wr_delta_b = '0;
    wr_dur = '0; num_entries = '0; gap_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", 32'({delta_a, delta_b, tone_on, busy, cur_idx, done}), 32'd0);
    rst = 1'b0;

    // 1: two entries, no gap, one-shot
    wr(0, 100, 200, 4);
    wr(1, 300, 50, 2);
    num_entries = 5'd2; gap_len = '0; loop = 1'b0;
    d0 = done_cnt;
    pulse_start();
    chk("t1_first_delta_a", 32'(delta_a), 32'd100);
    chk("t1_first_delta_b", 32'(delta_b), 32'd200);
    run_count("t1", n);
    chk("t1_busy_cycles", 32'(n), 32'd7);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 2: gap of 3 after every tone
    gap_len = 16'd3;
    d0 = done_cnt;
    pulse_start();
    run_count("t2", n);
    chk("t2_busy_cycles", 32'(n), 32'd13);
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 3: looping, then loop cleared during entry 1
    gap_len = '0; loop = 1'b1;
    d0 = done_cnt;
    pulse_start();
    chk("t3_idx_a", 32'(cur_idx), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_idx_b", 32'(cur_idx), 32'd1);
    repeat (2) @(negedge clk);
    chk("t3_idx_c", 32'(cur_idx), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_idx_d", 32'(cur_idx), 32'd1);
    loop = 1'b0;
    run_count("t3", n);
    chk("t3_tail_cycles", 32'(n), 32'd3);
    chk("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t3_idx_hold", 32'(cur_idx), 32'd1);

    // 4: stop together with start mid-tone, then start+stop while idle
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_out", 32'({delta_a, delta_b, tone_on}), 32'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // 5a: zero-duration entry plays one cycle
    wr(2, 11, 22, 0);
    num_entries = 5'd3;
    pulse_start();
    run_count("t5a", n);
    chk("t5a_busy_cycles", 32'(n), 32'd8);

    // 5b: nothing to play
    num_entries = 5'd0;
    d0 = done_cnt;
    pulse_start();
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_no_done", 32'(done_cnt - d0), 32'd0);

    // 5c/5d: oversize count clamps to 16 entries; restart while busy ignored
    for (int i = 0; i < 16; i++) wr(i, 10 + i, 500 - i, 1);
    num_entries = 5'd31;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("t5d_idx_before", 32'(cur_idx), 32'd2);
    pulse_start();
    chk("t5d_idx_after", 32'(cur_idx), 32'd3);
    run_count("t5c", n);
    chk("t5c_tail_cycles", 32'(n), 32'd14);
    chk("t5c_last_idx", 32'(cur_idx), 32'd15);

    // 6: rewrite the playing entry in a loop, then reset mid-run
    wr(0, 100, 200, 4);
    wr(1, 300, 50, 2);
    num_entries = 5'd2; loop = 1'b1;
    pulse_start();
    repeat (4) @(negedge clk);
    wr(1, 7, 9, 2);
    chk("t6_old_delta_a", 32'(delta_a), 32'd300);
    repeat (5) @(negedge clk);
    chk("t6_new_delta_a", 32'(delta_a), 32'd7);
    chk("t6_new_delta_b", 32'(delta_b), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; loop = 1'b0;
    chk("t6_reset_outputs", 32'({delta_a, delta_b, tone_on, busy, cur_idx, done}), 32'd0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Programmable scheduler that drives the two phase-increment inputs (delta_a, delta_b) of the dual-sine summing generator. It holds a small table of tone entries, each a (delta_a, delta_b, duration) triple, and plays them in order with an optional silent gap between entries. Playback is one-shot or looping. The block sits between the control/config interface and the sine-sum datapath, and provides the datapath with a tone_on mute qualifier.

Parameters:
DEPTH, 16, number of table entries
AW, 4, table address width (log2 DEPTH)
DW, 12, phase-increment width, matching the sine generator delta inputs
CW, 16, duration and gap counter width

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_delta_a  in  DW  entry delta_a
wr_delta_b  in  DW  entry delta_b
wr_dur  in  CW  entry duration in cycles (0 is treated as 1)
num_entries  in  AW+1  entries to play (0 = nothing; values above DEPTH clamp to DEPTH)
gap_len  in  CW  silent cycles between entries (0 = no gap)
loop  in  1  1 = restart at entry 0 after the last entry
start  in  1  single-cycle start pulse
stop  in  1  single-cycle abort pulse
delta_a  out  DW  phase increment to sine generator A
delta_b  out  DW  phase increment to sine generator B
tone_on  out  1  high while a tone entry is playing
busy  out  1  high in any state other than IDLE
cur_idx  out  AW  index of the entry currently playing or last played
done  out  1  single-cycle pulse at normal end of a one-shot run

Behaviour:
- Reset: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: delta_a=0, delta_b=0, tone_on=0, busy=0, cur_idx=0, done=0, state=IDLE. Table contents are not reset.
- States and transitions:
  - IDLE:
    - start && !stop && num_entries!=0 -> TONE with idx 0.
    - start with num_entries==0 -> stays in IDLE, no done pulse.
  - TONE:
    - Outputs are loaded from table[idx]; tone_on=1.
    - Dwell is exactly max(dur,1) cycles.
    - At expiry: if gap_len!=0 -> GAP; else advance directly.
  - GAP:
    - delta_a=delta_b=0, tone_on=0, for exactly gap_len cycles, then advance.
  - Advance:
    - If idx < last, go to TONE with idx+1.
    - If idx == last and loop==1, go to TONE with idx 0.
    - Otherwise go to DONE.
  - DONE:
    - One cycle: done=1, busy=1, deltas 0.
    - Next state IDLE.
- Latency:
  - start sampled at edge t -> entry 0 visible on delta_a/delta_b/tone_on from cycle t+1.
  - Back-to-back entries with gap_len=0 switch with no idle cycle.
- Configuration sampling:
  - num_entries (clamped) and gap_len are latched at start and held for the run.
  - loop is live, so clearing it mid-run ends playback after the current last entry.
- Table entry loading:
  - The entry is read when entering TONE and held in output/counter registers.
  - A write to the entry being played takes effect at its next load.
  - A write and a read of the same address in the same cycle returns the old data.
- stop:
  - Any non-IDLE state -> IDLE on the next cycle; outputs are zeroed; no done pulse.
  - stop wins over a simultaneous start.
  - stop in IDLE has no effect.
- start while busy is ignored.
- rst mid-run forces reset values on the next edge regardless of state.
- cur_idx wrap: it returns to 0 when looping; it holds the last index after DONE/stop until the next start.

Decomposition:
- Shared package holds:
  - state enum (IDLE, TONE, GAP, DONE)
  - DW and CW defaults
  - table entry struct {delta_a, delta_b, dur}
- One natural sub-module, tone_table: DEPTH-entry register file with a synchronous write port and a combinational read port.
- The FSM and the dwell/gap down-counter stay in tone_sequencer.

Test Plan:
1. Program entries 0:(100,200,dur 4) and 1:(300,50,dur 2); num_entries=2, gap_len=0, loop=0; start -> deltas 100/200 for 4 cycles, then 300/50 for 2 cycles, then one cycle of DONE with done=1, then IDLE with deltas 0 and busy=0.
2. Same table with gap_len=3 -> after each tone, 3 cycles of delta 0 and tone_on=0; total busy time = 4+3+2+3+1 = 13 cycles.
3. loop=1 with 2 entries -> cur_idx sequence 0,1,0,1; clear loop during entry 1 -> finishes entry 1 (plus gap), then a done pulse.
4. stop during the cycle-2 tone of entry 0, asserted together with start -> IDLE next cycle, no done; start+stop in IDLE -> stays IDLE.
5. Boundaries:
   - wr_dur=0 entry -> plays 1 cycle.
   - num_entries=0 -> start ignored.
   - num_entries=31 -> plays all 16 entries.
   - start while busy -> no restart.
6. Rewrite entry 1 to (7,9) while entry 1 is playing in a loop -> current pass keeps the old values; next pass outputs 7/9. Assert rst mid-run -> all outputs 0 on the next edge.
